// File: rtl/mar_ram.sv
// Memory stage of the SAP-style CPU: memory address register, memory data
// register and a small RAM with a combinational bus read port and a loader write port.
module mar_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_addr_load_n,
    input  logic              mar_mem_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] md_q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // MAR and MD: loaded from the bus only while the CPU owns the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q <= '0;
            md_q  <= '0;
        end else if (!prog_mode) begin
            if (!mar_addr_load_n) mar_q <= bus_in[ADDR_W-1:0];
            if (!mar_mem_load_n)  md_q  <= bus_in;
        end
    end

    // RAM array; CPU writes use the pre-edge MAR/MD so same-cycle loads do not race
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (prog_mode) begin
            if (prog_we) mem[prog_addr] <= prog_data;
        end else if (!ram_load_n) begin
            mem[mar_q] <= md_q;
        end
    end

    // Zero-latency read so the consumer can latch on the same edge
    assign bus_oe  = ~ram_en_n & ~prog_mode;
    assign bus_out = bus_oe ? mem[mar_q] : '0;

endmodule

// File: tb/tb_mar_ram.sv
// Self-checking bench for mar_ram: directed test-plan scenarios plus
// randomized traffic compared every cycle against a behavioural memory model.
module tb_mar_ram;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] bus_in;
    logic              ma_n, md_n, ce_n, lr_n;
    logic              prog_mode, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] md_q;

    int checks = 0;
    int errors = 0;

    mar_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_in          (bus_in),
        .mar_addr_load_n (ma_n),
        .mar_mem_load_n  (md_n),
        .ram_en_n        (ce_n),
        .ram_load_n      (lr_n),
        .prog_mode       (prog_mode),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .mar_q           (mar_q),
        .md_q            (md_q)
    );

    always #5 clk = ~clk;

    // Reference model: the memory contents and the two registers as plain variables
    int m_mem [DEPTH];
    int m_mar;
    int m_md;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_mar = 0;
            m_md  = 0;
        end else begin
            int new_mar, new_md;
            new_mar = m_mar;
            new_md  = m_md;
            if (prog_mode) begin
                if (prog_we) m_mem[prog_addr] = prog_data;
            end else begin
                if (!lr_n) m_mem[m_mar] = m_md;
                if (!ma_n) new_mar = bus_in % DEPTH;
                if (!md_n) new_md  = bus_in;
            end
            m_mar = new_mar;
            m_md  = new_md;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, sampled between the drive edge and the active edge
    always @(negedge clk) begin
        #1;
        begin
            int exp_oe, exp_out;
            exp_oe  = (!ce_n && !prog_mode) ? 1 : 0;
            exp_out = exp_oe ? m_mem[m_mar] : 0;
            chk("cyc_bus_oe", int'(bus_oe), exp_oe);
            chk("cyc_bus_out", int'(bus_out), exp_out);
            chk("cyc_mar_q", int'(mar_q), m_mar);
            chk("cyc_md_q", int'(md_q), m_md);
        end
    end

    task automatic go(input logic [7:0] b, input logic ma, input logic md,
                      input logic ce, input logic lr, input logic pm,
                      input logic we, input logic [3:0] pa, input logic [7:0] pd);
        @(negedge clk);
        bus_in    = b;
        ma_n      = ma;
        md_n      = md;
        ce_n      = ce;
        lr_n      = lr;
        prog_mode = pm;
        prog_we   = we;
        prog_addr = pa;
        prog_data = pd;
    endtask

    task automatic idle();
        go(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic ld_mar(input logic [7:0] b);
        go(b, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic ld_md(input logic [7:0] b);
        go(b, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic wr_ram();
        go(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic rd_ram();
        go(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        go(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_in = '0; ma_n = 1'b1; md_n = 1'b1; ce_n = 1'b1; lr_n = 1'b1;
        prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_bus_oe", int'(bus_oe), 0);
        chk("reset_bus_out", int'(bus_out), 0);
        chk("reset_mar", int'(mar_q), 0);
        chk("reset_md", int'(md_q), 0);
        rst_n = 1'b1;

        // Program load then fetch
        prog(4'd0, 8'h4E);
        prog(4'd14, 8'h07);
        ld_mar(8'h00);
        rd_ram(); #2;
        chk("fetch0_oe", int'(bus_oe), 1);
        chk("fetch0_data", int'(bus_out), 'h4E);
        ld_mar(8'hFE);
        rd_ram(); #2;
        chk("fetch14_mar", int'(mar_q), 'hE);
        chk("fetch14_data", int'(bus_out), 'h07);

        // STA sequence
        ld_mar(8'h09);
        ld_md(8'hA5);
        wr_ram();
        rd_ram(); #2;
        chk("sta_data", int'(bus_out), 'hA5);

        // Simultaneous write with MAR and MD loads
        ld_mar(8'h03);
        ld_md(8'h11);
        go(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        idle(); #2;
        chk("simul_mar", int'(mar_q), 2);
        chk("simul_md", int'(md_q), 'h22);
        rd_ram(); #2;
        chk("simul_ram2", int'(bus_out), 0);
        ld_mar(8'h03);
        rd_ram(); #2;
        chk("simul_ram3", int'(bus_out), 'h11);

        // Read during write
        ld_mar(8'h04);
        ld_md(8'h10);
        wr_ram();
        ld_md(8'h99);
        go(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00); #2;
        chk("rdw_old", int'(bus_out), 'h10);
        rd_ram(); #2;
        chk("rdw_new", int'(bus_out), 'h99);

        // Mode isolation
        go(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00); #2;
        chk("iso_oe", int'(bus_oe), 0);
        chk("iso_out", int'(bus_out), 0);
        idle(); #2;
        chk("iso_mar", int'(mar_q), 4);
        chk("iso_md", int'(md_q), 'h99);
        go(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h4, 8'h55);
        rd_ram(); #2;
        chk("iso_ram", int'(bus_out), 'h99);

        // Reset mid-operation
        ld_mar(8'h05);
        ld_md(8'h3C);
        wr_ram();
        rd_ram(); #2;
        chk("prerst_ram5", int'(bus_out), 'h3C);
        idle(); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mar", int'(mar_q), 0);
        chk("midrst_md", int'(md_q), 0);
        chk("midrst_oe", int'(bus_oe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ld_mar(8'h05);
        rd_ram(); #2;
        chk("postrst_ram5", int'(bus_out), 0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            go(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
        end
        idle();
        @(negedge clk); #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mar_ram.md
Name: mar_ram

Overview:
Memory stage of the 8-bit SAP-style CPU. It holds the memory address register (MAR), the memory data register (MD) and a 2**ADDR_W x DATA_W RAM. It consumes the active-low memory control lines produced by the control block: \L_MA, \L_MD, \CE and \L_R. It drives the shared bus during instruction fetch and operand reads. A program-load port lets the external loader fill RAM while the CPU is held.

Parameters:
ADDR_W, 4, MAR / RAM address width; RAM depth = 2**ADDR_W
DATA_W, 8, bus, MD and RAM word width

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
bus_in  in  DATA_W  shared bus value (PC, IR operand or register A)
mar_addr_load_n  in  1  \L_MA: load MAR from bus_in[ADDR_W-1:0]
mar_mem_load_n  in  1  \L_MD: load MD from bus_in
ram_en_n  in  1  \CE: drive RAM[MAR] onto bus
ram_load_n  in  1  \L_R: write MD into RAM[MAR]
prog_mode  in  1  1 = loader owns RAM; CPU control lines ignored
prog_we  in  1  loader write strobe; qualified by prog_mode
prog_addr  in  ADDR_W  loader write address
prog_data  in  DATA_W  loader write data
bus_out  out  DATA_W  RAM[MAR] when bus_oe, else 0
bus_oe  out  1  bus drive enable
mar_q  out  ADDR_W  current MAR value (debug / bench visibility)
md_q  out  DATA_W  current MD value

Behaviour:
- Reset (rst_n=0, asynchronous): MAR=0, MD=0, all RAM words=0. Outputs then read bus_out=0, bus_oe=0, mar_q=0, md_q=0. Reset takes effect immediately, mid-cycle included. A write in flight at assertion is lost.
- Control inputs are sampled at posedge. They are stable by then because the control block updates them on negedge.
- CPU mode (prog_mode=0):
  - \L_MA=0: MAR <= bus_in[ADDR_W-1:0]. Upper bus bits are ignored.
  - \L_MD=0: MD <= bus_in.
  - \L_R=0: RAM[MAR] <= MD, using the pre-edge MAR and MD values.
  - \L_R together with \L_MD or \L_MA in the same cycle: the write uses the old MD and the old MAR. All registers update in parallel.
  - prog_we is ignored.
- Read path (combinational):
  - bus_oe = ~ram_en_n & ~prog_mode.
  - bus_out = bus_oe ? RAM[MAR] : 0.
  - Zero latency: IR/A/B latch the read on the same posedge that \CE is low.
- \CE=0 and \L_R=0 together: bus_out shows the pre-write word for the whole cycle. The new word is visible from the next cycle.
- Program mode (prog_mode=1):
  - prog_we=1: RAM[prog_addr] <= prog_data at posedge.
  - MAR and MD hold. All four CPU control lines are ignored; bus_oe=0.
  - Any number of back-to-back writes is allowed, one per cycle. Writing the same address twice keeps the last value.
- prog_mode transitions take effect at the sampling edge; there is no pipeline. A prog write on the final prog_mode=1 cycle completes. CPU control on the first prog_mode=0 cycle is honoured.
- MAR wraps naturally. Address 2**ADDR_W-1 is valid; there is no out-of-range case.
- No other state exists. The block never stalls and has no ready/valid back-pressure.

Test Plan:
- Reset mid-operation: MAR=5, MD=0x3C, RAM[5]=0x3C, then pulse rst_n low asynchronously between edges -> mar_q=0, md_q=0, RAM[5]=0, bus_oe=0 immediately.
- Program load then fetch: prog_mode=1; write RAM[0]=0x4E, RAM[14]=0x07; prog_mode=0; bus_in=0x00 with \L_MA=0; next cycle \CE=0 -> bus_oe=1, bus_out=0x4E in the same cycle. Then \L_MA with bus_in=0xFE -> mar_q=0xE, and \CE -> bus_out=0x07.
- STA sequence: \L_MA with bus_in=0x09; \L_MD with bus_in=0xA5; \L_R one cycle -> RAM[9]=0xA5. Verify via \CE read: bus_out=0xA5.
- Simultaneous: MAR=3, MD=0x11; one cycle with \L_R=0, \L_MD=0, \L_MA=0, bus_in=0x22 -> RAM[3]=0x11, MD=0x22, MAR=2, RAM[2] unchanged.
- Read-during-write: MAR=4, RAM[4]=0x10, MD=0x99; \CE=0 and \L_R=0 same cycle -> bus_out=0x10 during the cycle, 0x99 on the next \CE.
- Mode isolation: prog_mode=1 with \L_MA=\L_MD=\L_R=\CE=0 and bus_in=0xFF -> MAR, MD and RAM unchanged, bus_oe=0. Then prog_mode=0 and prog_we=1 -> no RAM write.
